fp_adder_arbiter: RTL and testbench
===================================

# fp_adder_arbiter

Two-port round-robin arbiter and scheduler that shares one pipelined `ieee_adder` (single-precision add/subtract) between two independent requesters. It accepts at most one operation per cycle over a valid/ready handshake and drives the adder's `add_sub_bit`, `inputA` and `inputB` from an issue register. A tag shift register matched to the adder latency steers each `outputC` result back to the requester that issued it. It sits between the adder instance and the compute clients that previously each needed a private adder.

## Interface
- `ADDER_LATENCY`, default 4: cycles from the acceptance edge to `outputC` holding that operation's result, issue register included. Legal range 2..16.
- `clock_in`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending.
- `req0_ready`, `req1_ready`  out  1  grant; the operation is accepted at an edge where valid&ready.
- `req0_add_sub`, `req1_add_sub`  in  1  0 = A+B, 1 = A−B.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  IEEE-754 single operands.
- `res0_valid`, `res1_valid`  out  1  one-cycle pulse; the result is on `res_data`.
- `res_data`  out  32  equal to `adder_c`; qualified only by `resN_valid`.
- `adder_add_sub`  out  1  to adder `add_sub_bit`.
- `adder_a`, `adder_b`  out  32  to adder `inputA`, `inputB`.
- `adder_c`  in  32  from adder `outputC`.
- `in_flight`  out  5  count of accepted operations whose result has not yet been delivered.

## Operation
- Grant (combinational from the valid inputs and the `last_grant` register):
  - Only one valid: grant it.
  - Both valid: grant the requester not named by `last_grant`.
  - Neither valid: no grant.
- `last_grant` updates only on an accepted transfer.
- Never more than one ready high at once. There is no backpressure from the adder, so a grant is always issued when any valid is high.
- On acceptance at edge k:
  - The issue register captures {add_sub, a, b} of the winner and drives `adder_*` from after edge k.
  - The tag pipe stage 0 captures {valid=1, id}.
- With no acceptance at an edge:
  - Tag stage 0 captures valid=0.
  - The issue register holds its previous value. The adder computes garbage, and it is never tagged valid.
- Tag pipe:
  - Depth `ADDER_LATENCY`; shifts every cycle unconditionally.
  - `resN_valid` = tail.valid & (tail.id==N).
- `in_flight`: +1 on acceptance, −1 when the tail is valid, unchanged when both occur in the same cycle. Maximum value is `ADDER_LATENCY`, and it never wraps.
- Result delivery has no ready. Requesters must sample `res_data` in the cycle `resN_valid` is high.
- Operand values are passed through unmodified: NaN, infinity and denormal handling belong to the adder.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - Clears `last_grant` to 1, so req0 wins the first tie.
  - Clears all tag valids, the issue register (0x00000000, add_sub 0), and `in_flight` to 0.
  - `res0_valid`, `res1_valid` are 0.
  - `req*_ready` follow the valid inputs combinationally even during reset, but no transfer is recorded while `reset_n`=0.
- Latency: an operation accepted at edge k has `resN_valid` high in the cycle after edge k+ADDER_LATENCY−1, i.e. it is sampled at edge k+ADDER_LATENCY.
- Throughput: 1 operation/cycle aggregate. Under continuous dual requests, grants strictly alternate 0,1,0,1…
- Results return in acceptance order. No two results are delivered in the same cycle.
- Reset mid-operation discards every in-flight tag. No `resN_valid` may pulse for operations accepted before reset.
- A valid deasserted without a handshake is legal and leaves arbitration state unchanged.

## Test plan
- Reset, then req0 only: 1.0+1.0 (0x3F800000, 0x3F800000, add_sub=0) accepted at edge k → `res0_valid` sampled at edge k+4, `res_data`=0x40000000, `res1_valid` stays 0, `in_flight` 1 then 0.
- Both valid on the same cycle after reset:
  - req0 2.0+0.5 and req1 3.0−1.0 (add_sub=1).
  - Required: req0 is granted first; req1 is granted the next cycle.
  - Required: `res0` 0x40200000 at k+4, then `res1` 0x40000000 at k+5.
- Continuous dual streams for 8 cycles:
  - req0 always 4.0+4.0 and req1 always 1.5+1.0.
  - Required: grants alternate every cycle.
  - Required: results alternate 0x41000000 / 0x40200000.
  - Required: `in_flight` saturates at 4 and never exceeds it.
- Idle gaps: req1 1.0+0.5 and 2.0+3.0 accepted with a 3-cycle gap → exactly two `res1_valid` pulses carrying 0x3FC00000 and 0x40A00000 at the matching cycles, and no pulses in between.
- Reset asserted asynchronously mid-clock with 3 operations in flight → all outputs are 0 immediately, with no result pulses afterwards. A post-reset 1.0+1.0 on req1 returns 0x40000000 with the normal 4-cycle latency.
- Parameter sweep with `ADDER_LATENCY`=2 and 8 against a matching adder model: the same sequence returns identical values, with latency equal to the parameter.

Source files
------------

// File: rtl/fp_adder_arbiter_if.sv
// Bundle between the shared-adder arbiter, its two requesters and the adder instance.
// slave is the arbiter side; master is the combined client/adder side.
interface fp_adder_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic              req0_add_sub;
  logic              req1_add_sub;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              res0_valid;
  logic              res1_valid;
  logic [DATA_W-1:0] res_data;
  logic              adder_add_sub;
  logic [DATA_W-1:0] adder_a;
  logic [DATA_W-1:0] adder_b;
  logic [DATA_W-1:0] adder_c;
  logic [4:0]        in_flight;

  modport slave (
    input  req0_valid, req1_valid, req0_add_sub, req1_add_sub,
    input  req0_a, req0_b, req1_a, req1_b, adder_c,
    output req0_ready, req1_ready, res0_valid, res1_valid, res_data,
    output adder_add_sub, adder_a, adder_b, in_flight
  );

  modport master (
    output req0_valid, req1_valid, req0_add_sub, req1_add_sub,
    output req0_a, req0_b, req1_a, req1_b, adder_c,
    input  req0_ready, req1_ready, res0_valid, res1_valid, res_data,
    input  adder_add_sub, adder_a, adder_b, in_flight
  );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Round-robin scheduler sharing one pipelined single-precision adder between two
// requesters; a tag pipe matched to the adder latency routes each result home.
module fp_adder_arbiter #(
  parameter int ADDER_LATENCY = 4
) (
  input  logic               clock_in,
  input  logic               reset_n,
  fp_adder_arbiter_if.slave  bus
);
  localparam int L = ADDER_LATENCY;

  logic         r_last_grant;
  logic         r_add_sub_p0;
  logic [31:0]  r_a_p0;
  logic [31:0]  r_b_p0;
  logic [L-1:0] r_tag_vld;
  logic [L-1:0] r_tag_id;
  logic [4:0]   r_in_flight;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_tail_vld;
  logic w_tail_id;

  // last_grant==1 means req1 won last, so req0 takes the next tie
  assign w_grant0   = bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1   = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_accept   = w_grant0 | w_grant1;
  assign w_tail_vld = r_tag_vld[L-1];
  assign w_tail_id  = r_tag_id[L-1];

  assign bus.req0_ready    = w_grant0;
  assign bus.req1_ready    = w_grant1;
  assign bus.adder_add_sub = r_add_sub_p0;
  assign bus.adder_a       = r_a_p0;
  assign bus.adder_b       = r_b_p0;
  assign bus.res0_valid    = w_tail_vld & ~w_tail_id;
  assign bus.res1_valid    = w_tail_vld & w_tail_id;
  assign bus.res_data      = bus.adder_c;
  assign bus.in_flight     = r_in_flight;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end

  // Issue stage: operands held between acceptances feed the adder directly
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_add_sub_p0 <= 1'b0;
      r_a_p0       <= 32'h0000_0000;
      r_b_p0       <= 32'h0000_0000;
    end else if (w_accept) begin
      r_add_sub_p0 <= w_grant1 ? bus.req1_add_sub : bus.req0_add_sub;
      r_a_p0       <= w_grant1 ? bus.req1_a       : bus.req0_a;
      r_b_p0       <= w_grant1 ? bus.req1_b       : bus.req0_b;
    end
  end

  // Tag pipe: one stage per adder cycle, tail aligned with outputC
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[L-2:0], w_accept};
    end
  end

  always_ff @(posedge clock_in) begin
    r_tag_id <= {r_tag_id[L-2:0], w_grant1};
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_in_flight <= 5'd0;
    end else begin
      case ({w_accept, w_tail_vld})
        2'b10:   r_in_flight <= r_in_flight + 5'd1;
        2'b01:   r_in_flight <= r_in_flight - 5'd1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench: three arbiter instances (latency 4, 2, 8) with behavioural
// adders share one stimulus stream; each checks grants, results and in_flight.
module tb_fp_adder_arbiter;
  localparam logic [31:0] F0P5 = 32'h3F00_0000;
  localparam logic [31:0] F1P0 = 32'h3F80_0000;
  localparam logic [31:0] F1P5 = 32'h3FC0_0000;
  localparam logic [31:0] F2P0 = 32'h4000_0000;
  localparam logic [31:0] F2P5 = 32'h4020_0000;
  localparam logic [31:0] F3P0 = 32'h4040_0000;
  localparam logic [31:0] F4P0 = 32'h4080_0000;
  localparam logic [31:0] F5P0 = 32'h40A0_0000;
  localparam logic [31:0] F8P0 = 32'h4100_0000;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          k;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pend [3];

  logic        s_v0, s_as0, s_v1, s_as1;
  logic [31:0] s_a0, s_b0, s_e0, s_a1, s_b1, s_e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) begin
      d = {x[31], 63'd0};
    end else begin
      e = {3'd0, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic sub, input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = sp2r(a);
    rb = sp2r(b);
    return r2sp(sub ? (ra - rb) : (ra + rb));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 4 : ((g == 1) ? 2 : 8);

    fp_adder_arbiter_if bus ();
    logic [31:0] pipe [LAT-1];
    exp_t q [$];
    logic lg = 1'b1;

    assign bus.req0_valid   = s_v0;
    assign bus.req0_add_sub = s_as0;
    assign bus.req0_a       = s_a0;
    assign bus.req0_b       = s_b0;
    assign bus.req1_valid   = s_v1;
    assign bus.req1_add_sub = s_as1;
    assign bus.req1_a       = s_a1;
    assign bus.req1_b       = s_b1;
    assign bus.adder_c      = pipe[LAT-2];

    fp_adder_arbiter #(.ADDER_LATENCY(LAT)) u_dut (
      .clock_in (clk),
      .reset_n  (rst_n),
      .bus      (bus.slave)
    );

    always @(posedge clk) begin
      pipe[0] <= fadd(bus.adder_add_sub, bus.adder_a, bus.adder_b);
      for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin : mon
      int   n;
      exp_t e;
      logic eg0, eg1;
      if (!rst_n) begin
        q.delete();
        lg = 1'b1;
      end
      n = 0;
      foreach (q[i]) if (q[i].k <= cyc) n++;
      chk($sformatf("L%0d in_flight", LAT), 32'(bus.in_flight), n);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk($sformatf("L%0d res0_valid", LAT), 32'(bus.res0_valid), 32'(!e.id));
        chk($sformatf("L%0d res1_valid", LAT), 32'(bus.res1_valid), 32'(e.id));
        chk($sformatf("L%0d res_data", LAT), bus.res_data, e.data);
      end else begin
        chk($sformatf("L%0d res0_idle", LAT), 32'(bus.res0_valid), 32'd0);
        chk($sformatf("L%0d res1_idle", LAT), 32'(bus.res1_valid), 32'd0);
      end
      eg0 = s_v0 & (~s_v1 | lg);
      eg1 = s_v1 & (~s_v0 | ~lg);
      chk($sformatf("L%0d ready0", LAT), 32'(bus.req0_ready), 32'(eg0));
      chk($sformatf("L%0d ready1", LAT), 32'(bus.req1_ready), 32'(eg1));
      if (rst_n && (eg0 || eg1)) begin
        e.id   = eg1;
        e.data = eg1 ? s_e1 : s_e0;
        e.k    = cyc + 1;
        e.due  = cyc + LAT;
        q.push_back(e);
        lg = eg1;
      end
      pend[g] = q.size();
    end
  end

  task automatic drive(input logic v0, input logic as0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] e0, input logic v1, input logic as1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [31:0] e1);
    @(posedge clk);
    #1;
    s_v0 = v0; s_as0 = as0; s_a0 = a0; s_b0 = b0; s_e0 = e0;
    s_v1 = v1; s_as1 = as1; s_a1 = a1; s_b1 = b1; s_e1 = e1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    s_v0 = 0; s_as0 = 0; s_a0 = 0; s_b0 = 0; s_e0 = 0;
    s_v1 = 0; s_as1 = 0; s_a1 = 0; s_b1 = 0; s_e1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_flight", 32'(g_inst[0].bus.in_flight), 32'd0);
    chk("rst res0_valid", 32'(g_inst[0].bus.res0_valid), 32'd0);
    chk("rst res1_valid", 32'(g_inst[0].bus.res1_valid), 32'd0);
    chk("rst adder_a", g_inst[0].bus.adder_a, 32'd0);
    chk("rst adder_b", g_inst[0].bus.adder_b, 32'd0);
    chk("rst adder_add_sub", 32'(g_inst[0].bus.adder_add_sub), 32'd0);
    rst_n = 1'b1;

    drive(1, 0, F1P0, F1P0, F2P0, 0, 0, 0, 0, 0);
    idle(10);

    do_reset();
    drive(1, 0, F2P0, F0P5, F2P5, 1, 1, F3P0, F1P0, F2P0);
    #1;
    chk("tie ready0", 32'(g_inst[0].bus.req0_ready), 32'd1);
    chk("tie ready1", 32'(g_inst[0].bus.req1_ready), 32'd0);
    drive(0, 0, 0, 0, 0, 1, 1, F3P0, F1P0, F2P0);
    #1;
    chk("second ready1", 32'(g_inst[0].bus.req1_ready), 32'd1);
    idle(10);

    for (int i = 0; i < 8; i++) drive(1, 0, F4P0, F4P0, F8P0, 1, 0, F1P5, F1P0, F2P5);
    idle(12);

    drive(0, 0, 0, 0, 0, 1, 0, F1P0, F0P5, F1P5);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0, F2P0, F3P0, F5P0);
    idle(12);

    drive(1, 0, F1P0, F1P0, F2P0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, F1P0, F1P0, F2P0);
    drive(1, 0, F1P0, F1P0, F2P0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-rst in_flight", 32'(g_inst[0].bus.in_flight), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async in_flight", 32'(g_inst[0].bus.in_flight), 32'd0);
    chk("async res0_valid", 32'(g_inst[0].bus.res0_valid), 32'd0);
    chk("async res1_valid", 32'(g_inst[0].bus.res1_valid), 32'd0);
    chk("async adder_a", g_inst[0].bus.adder_a, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, F1P0, F1P0, F2P0);
    idle(14);

    @(negedge clk);
    #1;
    chk("drain L4", pend[0], 32'd0);
    chk("drain L2", pend[1], 32'd0);
    chk("drain L8", pend[2], 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
